// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter: collects golden-nonce results from NUM_CORES hashcores,
// arbitrates them round-robin into a small FIFO and emits them as rate-limited
// single-cycle pulses towards the comm block.
// Optional build macro: GN_DROP_COUNT_EN adds a saturating drop_count output.
module golden_nonce_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_GAP    = 8
) (
  input  logic                        hash_clk,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        gn_match_i,
  input  logic [NUM_CORES*32-1:0]     golden_nonce_i,
  input  logic                        new_work,
  output logic                        is_golden_ticket,
  output logic [31:0]                 golden_nonce,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef GN_DROP_COUNT_EN
  ,
  output logic [15:0]                 drop_count
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int GW    = $clog2(OUT_GAP);

  typedef enum logic {
    IDLE,
    GAP
  } state_t;

  logic [NUM_CORES-1:0] pending;
  logic [31:0]          hold [NUM_CORES];
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] grant_vec;
  logic [PTR_W-1:0]     grant_idx;
  int                   scan;

  logic [31:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  state_t               state;
  state_t               state_next;
  logic [GW-1:0]        gap_cnt;
  logic [GW-1:0]        gap_next;
  logic                 tick_next;
  logic [31:0]          nonce_next;

  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);

  // Round-robin search for the first pending core at or after rr_ptr; a slot is freed by a same-edge pop.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    push      = 1'b0;
    scan      = 0;
    if (!new_work && (!fifo_full || pop)) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        scan = int'(rr_ptr) + i;
        if (scan >= NUM_CORES) scan = scan - NUM_CORES;
        if (!push && pending[scan]) begin
          push            = 1'b1;
          grant_vec[scan] = 1'b1;
          grant_idx       = PTR_W'(scan);
        end
      end
    end
  end

  // Per-core capture registers; a granted core may re-capture on the same edge its result leaves.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      rr_ptr  <= '0;
      for (int k = 0; k < NUM_CORES; k++) hold[k] <= '0;
    end else if (new_work) begin
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (gn_match_i[k] && (!pending[k] || grant_vec[k])) begin
          hold[k]    <= golden_nonce_i[k*32 +: 32];
          pending[k] <= 1'b1;
        end else if (grant_vec[k]) begin
          pending[k] <= 1'b0;
        end
      end
      if (push) rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_CORES);
    end
  end

  // Result FIFO with wrap-around pointers and a registered occupancy count.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int d = 0; d < FIFO_DEPTH; d++) mem[d] <= '0;
    end else if (new_work) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= hold[grant_idx];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Emitter next-state: pop and pulse from IDLE, then hold off for OUT_GAP edges in GAP.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    tick_next  = 1'b0;
    nonce_next = golden_nonce;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          nonce_next = mem[rd_ptr];
          tick_next  = 1'b1;
          state_next = GAP;
          gap_next   = GW'(OUT_GAP - 1);
        end
      end
      GAP: begin
        gap_next = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (new_work) begin
      state_next = IDLE;
      gap_next   = '0;
      tick_next  = 1'b0;
      nonce_next = golden_nonce;
      pop        = 1'b0;
    end
  end

  // Emitter state and registered outputs.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      gap_cnt          <= '0;
      is_golden_ticket <= 1'b0;
      golden_nonce     <= '0;
    end else begin
      state            <= state_next;
      gap_cnt          <= gap_next;
      is_golden_ticket <= tick_next;
      golden_nonce     <= nonce_next;
    end
  end

`ifdef GN_DROP_COUNT_EN
  localparam int DW = $clog2(NUM_CORES + 1);
  logic [DW-1:0] drop_now;

  // Count results lost this edge: overwrites of a still-pending core, or any match swallowed by a flush.
  always_comb begin
    drop_now = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (gn_match_i[k] && (new_work || (pending[k] && !grant_vec[k]))) drop_now = drop_now + DW'(1);
    end
  end

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (({1'b0, drop_count} + 17'(drop_now)) > 17'h0FFFF) begin
      drop_count <= 16'hFFFF;
    end else begin
      drop_count <= drop_count + 16'(drop_now);
    end
  end
`endif

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Testbench for golden_nonce_arbiter: directed and randomized stimulus checked
// against a queue-based reference model of the result path.
module tb_golden_nonce_arbiter;

  localparam int NC   = 2;
  localparam int FD   = 4;
  localparam int GAPC = 8;
  localparam int LW   = $clog2(FD) + 1;

  logic              hash_clk = 1'b0;
  logic              reset_n;
  logic [NC-1:0]     gn_match_i;
  logic [NC*32-1:0]  golden_nonce_i;
  logic              new_work;
  logic              is_golden_ticket;
  logic [31:0]       golden_nonce;
  logic [LW-1:0]     fifo_level;
`ifdef GN_DROP_COUNT_EN
  logic [15:0]       drop_count;
`endif

  int checks     = 0;
  int failures   = 0;
  int cycle      = 0;
  int last_pulse = -1;

  // Reference model state
  bit          m_pend [NC];
  logic [31:0] m_hold [NC];
  logic [31:0] m_q [$];
  int          m_rr;
  int          m_cool;
  logic        m_tick;
  logic [31:0] m_nonce;
  int          m_drops;

  golden_nonce_arbiter #(
    .NUM_CORES (NC),
    .FIFO_DEPTH(FD),
    .OUT_GAP   (GAPC)
  ) dut (
    .hash_clk        (hash_clk),
    .reset_n         (reset_n),
    .gn_match_i      (gn_match_i),
    .golden_nonce_i  (golden_nonce_i),
    .new_work        (new_work),
    .is_golden_ticket(is_golden_ticket),
    .golden_nonce    (golden_nonce),
    .fifo_level      (fifo_level)
`ifdef GN_DROP_COUNT_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  // Free-running hashing clock
  always #5 hash_clk = ~hash_clk;

  function automatic void modelReset();
    for (int k = 0; k < NC; k++) begin
      m_pend[k] = 1'b0;
      m_hold[k] = '0;
    end
    m_q.delete();
    m_rr       = 0;
    m_cool     = 0;
    m_tick     = 1'b0;
    m_nonce    = '0;
    m_drops    = 0;
    last_pulse = -1;
  endfunction

  function automatic void modelStep(input logic [NC-1:0] match, input logic [NC*32-1:0] nonces, input logic nw);
    int g;
    bit do_pop;
    logic [31:0] head;
    if (nw) begin
      for (int k = 0; k < NC; k++) if (match[k]) m_drops++;
      for (int k = 0; k < NC; k++) m_pend[k] = 1'b0;
      m_q.delete();
      m_rr       = 0;
      m_cool     = 0;
      m_tick     = 1'b0;
      last_pulse = -1;
      return;
    end
    do_pop = (m_cool == 0) && (m_q.size() > 0);
    head   = '0;
    g      = -1;
    if ((m_q.size() < FD) || do_pop) begin
      for (int i = 0; i < NC; i++) begin
        int c;
        c = (m_rr + i) % NC;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (do_pop) head = m_q.pop_front();
    if (g >= 0) begin
      m_q.push_back(m_hold[g]);
      m_pend[g] = 1'b0;
      m_rr      = (g + 1) % NC;
    end
    for (int k = 0; k < NC; k++) begin
      if (match[k]) begin
        if (!m_pend[k]) begin
          m_hold[k] = nonces[k*32 +: 32];
          m_pend[k] = 1'b1;
        end else begin
          m_drops++;
        end
      end
    end
    if (do_pop) begin
      m_tick  = 1'b1;
      m_nonce = head;
      m_cool  = GAPC - 1;
    end else begin
      m_tick = 1'b0;
      if (m_cool > 0) m_cool--;
    end
  endfunction

  task automatic checkOutput(input string tag);
    logic [LW-1:0] exp_level;
    exp_level = LW'(m_q.size());
    checks++;
    assert (is_golden_ticket === m_tick) else begin
      failures++;
      $error("[TB] FAIL %s ticket: observed=%b expected=%b (cycle %0d)", tag, is_golden_ticket, m_tick, cycle);
    end
    checks++;
    assert (golden_nonce === m_nonce) else begin
      failures++;
      $error("[TB] FAIL %s nonce: observed=%h expected=%h (cycle %0d)", tag, golden_nonce, m_nonce, cycle);
    end
    checks++;
    assert (fifo_level === exp_level) else begin
      failures++;
      $error("[TB] FAIL %s level: observed=%0d expected=%0d (cycle %0d)", tag, fifo_level, exp_level, cycle);
    end
`ifdef GN_DROP_COUNT_EN
    checks++;
    assert (drop_count === 16'((m_drops > 65535) ? 65535 : m_drops)) else begin
      failures++;
      $error("[TB] FAIL %s drops: observed=%0d expected=%0d (cycle %0d)", tag, drop_count, m_drops, cycle);
    end
`endif
    if (is_golden_ticket === 1'b1) begin
      if (last_pulse >= 0) begin
        checks++;
        assert ((cycle - last_pulse) >= GAPC) else begin
          failures++;
          $error("[TB] FAIL %s spacing: observed=%0d expected>=%0d", tag, cycle - last_pulse, GAPC);
        end
      end
      last_pulse = cycle;
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] match, input logic [NC*32-1:0] nonces, input logic nw, input string tag);
    gn_match_i     = match;
    golden_nonce_i = nonces;
    new_work       = nw;
    @(posedge hash_clk);
    modelStep(match, nonces, nw);
    #1;
    cycle++;
    checkOutput(tag);
  endtask

  task automatic runIdle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus('0, {$urandom, $urandom}, 1'b0, tag);
  endtask

  initial begin
    bit seen;
    reset_n        = 1'b0;
    gn_match_i     = '0;
    golden_nonce_i = '0;
    new_work       = 1'b0;
    modelReset();
    $display("[TB] start");

    // Reset state
    @(posedge hash_clk);
    @(posedge hash_clk);
    #1;
    checkOutput("reset");
    reset_n = 1'b1;

    // Single match on core0
    applyStimulus(2'b01, {32'h0BAD_0BAD, 32'hA5A5_0001}, 1'b0, "single");
    runIdle(12, "single");

    // Simultaneous match on both cores
    applyStimulus(2'b11, {32'h2222_2222, 32'h1111_1111}, 1'b0, "simul");
    runIdle(20, "simul");

    // Both cores match every cycle: round-robin with FIFO saturation
    for (int i = 0; i < 20; i++) applyStimulus(2'b11, {$urandom, $urandom}, 1'b0, "fair");
    runIdle(60, "fair_drain");

    // Queue several results then flush
    applyStimulus(2'b11, {32'h3333_0002, 32'h3333_0001}, 1'b0, "flush");
    applyStimulus(2'b11, {32'h3333_0004, 32'h3333_0003}, 1'b0, "flush");
    applyStimulus(2'b01, {32'h3333_0006, 32'h3333_0005}, 1'b0, "flush");
    applyStimulus(2'b00, {32'h0, 32'h0}, 1'b0, "flush");
    applyStimulus(2'b10, {32'h3333_0008, 32'h3333_0007}, 1'b1, "flush_nw");
    runIdle(15, "flush_after");

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      logic [NC-1:0] mt;
      mt = NC'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) mt = '0;
      applyStimulus(mt, {$urandom, $urandom}, ($urandom_range(0, 80) == 0), "random");
    end
    runIdle(40, "random_drain");

    // Reset in the middle of the GAP phase
    applyStimulus(2'b10, {32'hC0DE_0002, 32'hC0DE_0001}, 1'b0, "rstgap");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus('0, {$urandom, $urandom}, 1'b0, "rstgap");
      if (m_tick) seen = 1'b1;
    end
    checks++;
    assert (seen === 1'b1) else begin
      failures++;
      $error("[TB] FAIL rstgap pulse_seen: observed=%b expected=1", seen);
    end
    runIdle(2, "rstgap");
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rstgap_async");
    @(posedge hash_clk);
    #1;
    checkOutput("rstgap_hold");
    reset_n = 1'b1;
    applyStimulus(2'b01, {32'h0, 32'h5EED_1234}, 1'b0, "post_reset");
    runIdle(12, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
